// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register self-test master.
// Contents:
//   RESP_OKAY / RESP_EXOKAY : AXI response encodings
//   err_code_e              : failure reason reported on err_code
//   state_e                 : sequencer state encoding
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_BRESP   = 3'd1,
        ERR_RRESP   = 3'd2,
        ERR_DATA    = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

endpackage

// File: rtl/axil_reg_selftest_master.sv
// AXI4-Lite self-test master. Writes NUM_REGS words (SEED + i*STRIDE) to
// consecutive registers starting at BASE_ADDR, reads each back immediately
// after writing it and compares. The first failure ends the run and is
// reported as an error code plus the register index.
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   start                 one-cycle pulse starting a run (ignored unless idle)
//   busy                  run in progress
//   done                  sticky run-finished flag, cleared by the next start
//   pass                  all registers matched (valid with done)
//   err_idx, err_code     failing register index and reason
//   M_AXI_*               AXI4-Lite master interface
//
// state | meaning
// IDLE  | waiting for start
// WR    | AW and W channels valid, each drops on its own handshake
// WB    | BREADY high, waiting for write response
// RA    | ARVALID high, waiting for ARREADY
// RD    | RREADY high, waiting for read data, then compare
// FIN   | result latched for one cycle, back to IDLE
module axil_reg_selftest_master
    import axil_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] SEED      = 32'h0101_FFFF,
    parameter logic [DATA_W-1:0] STRIDE    = 32'hAACB_0002,
    parameter int                TIMEOUT   = 255
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_idx,
    output logic [2:0]            err_code,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);
    // The counter holds the number of unmet cycles already seen; the
    // TIMEOUT-th unmet cycle is the one where it equals TIMEOUT-1.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e              state_q,   state_d;
    logic [7:0]          idx_q,     idx_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   acc_q,     acc_d;
    logic [15:0]         tmo_q,     tmo_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q,  wvalid_d;
    logic                bready_q,  bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q,  rready_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                pass_q,    pass_d;
    err_code_e           err_q,     err_d;
    logic [7:0]          err_idx_q, err_idx_d;

    logic                hs_done;
    logic                fin_req;
    err_code_e           fin_err;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            acc_q     <= '0;
            tmo_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= ERR_NONE;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            tmo_q     <= tmo_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        tmo_d     = tmo_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        hs_done   = 1'b0;
        fin_req   = 1'b0;
        fin_err   = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WR;
                    idx_d     = '0;
                    addr_d    = BASE_ADDR;
                    acc_d     = SEED;
                    tmo_d     = '0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = ERR_NONE;
                    err_idx_d = '0;
                end
            end
            ST_WR: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                hs_done = !awvalid_d && !wvalid_d;
                if (hs_done) begin
                    state_d  = ST_WB;
                    bready_d = 1'b1;
                end
            end
            ST_WB: begin
                if (M_AXI_BVALID) begin
                    hs_done  = 1'b1;
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != RESP_OKAY) begin
                        fin_req = 1'b1;
                        fin_err = ERR_BRESP;
                    end else begin
                        state_d   = ST_RA;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_RA: begin
                if (M_AXI_ARREADY) begin
                    hs_done   = 1'b1;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                if (M_AXI_RVALID) begin
                    hs_done  = 1'b1;
                    rready_d = 1'b0;
                    if (M_AXI_RRESP != RESP_OKAY) begin
                        fin_req = 1'b1;
                        fin_err = ERR_RRESP;
                    end else if (M_AXI_RDATA != acc_q) begin
                        fin_req = 1'b1;
                        fin_err = ERR_DATA;
                    end else if (idx_q == LAST_IDX) begin
                        fin_req = 1'b1;
                    end else begin
                        // Next register: address and expected data advance
                        // by addition only, wrapping naturally.
                        idx_d     = idx_q + 8'd1;
                        addr_d    = addr_q + ADDR_W'(4);
                        acc_d     = acc_q + STRIDE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Per-state handshake watchdog; cleared whenever the state advances.
        if (state_q == ST_WR || state_q == ST_WB ||
            state_q == ST_RA || state_q == ST_RD) begin
            if (hs_done) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                fin_req = 1'b1;
                fin_err = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end

        if (fin_req) begin
            state_d   = ST_FIN;
            tmo_d     = '0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = (fin_err == ERR_NONE);
            err_d     = fin_err;
            err_idx_d = (fin_err == ERR_NONE) ? 8'd0 : idx_q;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_idx       = err_idx_q;
    assign err_code      = err_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = acc_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_reg_selftest_master.sv
// Bench for axil_reg_selftest_master: a behavioural AXI4-Lite register slave
// with configurable per-channel delays and fault injection, a table of
// directed scenarios, hand-written reset/start corner sequences and a
// randomised loop checked against a reference model of the test run.
`timescale 1ns/1ps
module tb_axil_reg_selftest_master;
    import axil_pkg::*;

    localparam int          NUM_REGS = 4;
    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] SEED     = 32'h0101_FFFF;
    localparam logic [31:0] STRIDE   = 32'hAACB_0002;

    logic tb_ACLK   = 1'b0;
    logic tb_ARESET = 1'b1;
    always #5 tb_ACLK = ~tb_ACLK;

    logic        start;
    logic        busy, done, pass;
    logic [7:0]  err_idx;
    logic [2:0]  err_code;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axil_reg_selftest_master #(
        .NUM_REGS (NUM_REGS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESET        (tb_ARESET),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_idx       (err_idx),
        .err_code      (err_code),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    typedef struct packed {
        int aw_dly; int w_dly; int b_dly; int ar_dly; int r_dly;
        int bresp_bad; int rresp_bad; int data_bad; bit ar_hang;
    } knobs_t;

    typedef struct {
        knobs_t k; bit exp_pass; int exp_code; int exp_idx;
    } vec_t;

    knobs_t kn;
    logic   scrub;

    // ---------------- behavioural slave ----------------
    logic [31:0] mem [0:255];
    int          aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
    logic        aw_got, w_got, bvalid_r, rvalid_r;
    logic [7:0]  aw_idx;
    logic [31:0] w_dat, rdata_r;
    logic [1:0]  bresp_r, rresp_r;
    logic        aw_c, w_c, wr_complete;
    logic [7:0]  wr_idx;
    logic [31:0] wr_dat;

    assign awready     = awvalid && (aw_cnt >= kn.aw_dly);
    assign wready      = wvalid && (w_cnt >= kn.w_dly);
    assign arready     = arvalid && !kn.ar_hang && (ar_cnt >= kn.ar_dly);
    assign aw_c        = aw_got || (awvalid && awready);
    assign w_c         = w_got || (wvalid && wready);
    assign wr_complete = aw_c && w_c;
    assign wr_idx      = aw_got ? aw_idx : awaddr[9:2];
    assign wr_dat      = w_got ? w_dat : wdata;
    assign bvalid      = bvalid_r;
    assign bresp       = bresp_r;
    assign rvalid      = rvalid_r;
    assign rresp       = rresp_r;
    assign rdata       = rdata_r;

    always @(posedge tb_ACLK or posedge tb_ARESET) begin
        if (tb_ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
            aw_idx <= '0; w_dat <= '0; rdata_r <= '0; bresp_r <= '0; rresp_r <= '0;
        end else begin
            if (scrub)
                for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_0000 | i;
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (wr_complete) begin
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
                mem[wr_idx]  <= wr_dat;
                bresp_r      <= (int'(wr_idx) == kn.bresp_bad) ? 2'b10 : 2'b00;
                if (kn.b_dly == 0) bvalid_r <= 1'b1;
                else               b_wait   <= kn.b_dly;
            end else begin
                if (awvalid && awready) begin aw_got <= 1'b1; aw_idx <= awaddr[9:2]; end
                if (wvalid && wready)   begin w_got  <= 1'b1; w_dat  <= wdata;       end
            end
            if (b_wait > 0) begin
                b_wait <= b_wait - 1;
                if (b_wait == 1) bvalid_r <= 1'b1;
            end
            if (bvalid_r && bready) bvalid_r <= 1'b0;
            if (arvalid && arready) begin
                rdata_r <= mem[araddr[9:2]] ^ {31'd0, (int'(araddr[9:2]) == kn.data_bad)};
                rresp_r <= (int'(araddr[9:2]) == kn.rresp_bad) ? 2'b10 : 2'b00;
                if (kn.r_dly == 0) rvalid_r <= 1'b1;
                else               r_wait   <= kn.r_dly;
            end
            if (r_wait > 0) begin
                r_wait <= r_wait - 1;
                if (r_wait == 1) rvalid_r <= 1'b1;
            end
            if (rvalid_r && rready) rvalid_r <= 1'b0;
        end
    end

    // ---------------- activity monitor ----------------
    int n_aw_hs = 0, n_ar_hs = 0, n_busy = 0, n_arv = 0;
    always @(posedge tb_ACLK) begin
        if (!tb_ARESET) begin
            if (awvalid && awready) n_aw_hs <= n_aw_hs + 1;
            if (arvalid && arready) n_ar_hs <= n_ar_hs + 1;
            if (busy)               n_busy  <= n_busy + 1;
            if (arvalid)            n_arv   <= n_arv + 1;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: walks the registers in order, first injected fault wins;
    // a clean run costs (slowest of AW/W + 1) + (B + 1) + (AR + 1) + (R + 1)
    // cycles per register.
    function automatic void model(input knobs_t k, output bit p, output int code,
                                  output int idx, output int naw, output int nar,
                                  output int cyc);
        p = 1'b1; code = 0; idx = 0; naw = 0; nar = 0; cyc = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            naw++;
            if (k.bresp_bad == i) begin p = 1'b0; code = 1; idx = i; return; end
            if (k.ar_hang)        begin p = 1'b0; code = 4; idx = i; return; end
            nar++;
            if (k.rresp_bad == i) begin p = 1'b0; code = 2; idx = i; return; end
            if (k.data_bad == i)  begin p = 1'b0; code = 3; idx = i; return; end
            cyc += ((k.aw_dly > k.w_dly) ? k.aw_dly : k.w_dly) + 1
                 + k.b_dly + 1 + k.ar_dly + 1 + k.r_dly + 1;
        end
    endfunction

    function automatic knobs_t mkk(input int aw, input int w, input int b, input int ar,
                                   input int r, input int bb, input int rb, input int db,
                                   input bit hang);
        knobs_t k;
        k.aw_dly = aw; k.w_dly = w; k.b_dly = b; k.ar_dly = ar; k.r_dly = r;
        k.bresp_bad = bb; k.rresp_bad = rb; k.data_bad = db; k.ar_hang = hang;
        return k;
    endfunction

    function automatic vec_t mkv(input knobs_t k, input bit p, input int code, input int idx);
        vec_t v;
        v.k = k; v.exp_pass = p; v.exp_code = code; v.exp_idx = idx;
        return v;
    endfunction

    // Runs one test; returns in the FIN cycle (done just set).
    task automatic run(input string tag, input knobs_t k, input bit p,
                       input int code, input int idx);
        int  aw0, ar0, busy0, arv0, wt;
        bit  mp;
        int  mcode, midx, naw, nar, cyc;
        logic [31:0] want;
        model(k, mp, mcode, midx, naw, nar, cyc);
        @(negedge tb_ACLK); kn = k; scrub = 1'b1;
        @(negedge tb_ACLK); scrub = 1'b0;
        aw0 = n_aw_hs; ar0 = n_ar_hs; busy0 = n_busy; arv0 = n_arv;
        start = 1'b1;
        @(negedge tb_ACLK); start = 1'b0;
        check({tag, ".busy_after_start"}, busy, 1);
        wt = 0;
        while (!done && wt < 2000) begin @(negedge tb_ACLK); wt++; end
        check({tag, ".done"}, done, 1);
        check({tag, ".pass"}, pass, p);
        check({tag, ".err_code"}, err_code, code);
        check({tag, ".err_idx"}, err_idx, idx);
        check({tag, ".busy_low"}, busy, 0);
        check({tag, ".valids_low"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
        check({tag, ".aw_count"}, n_aw_hs - aw0, naw);
        check({tag, ".ar_count"}, n_ar_hs - ar0, nar);
        if (k.ar_hang) check({tag, ".arvalid_cycles"}, n_arv - arv0, TIMEOUT);
        if (p) begin
            check({tag, ".busy_cycles"}, n_busy - busy0, cyc);
            for (int i = 0; i < NUM_REGS; i++) begin
                want = SEED + 32'(i) * STRIDE;
                check($sformatf("%s.mem%0d", tag, i), mem[i], want);
            end
        end
    endtask

    vec_t vecs [0:10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int aw0, busy0, wt;
        bit mp;
        int mcode, midx, naw, nar, cyc;
        knobs_t rk;

        start = 1'b0;
        scrub = 1'b0;
        kn    = mkk(0, 0, 0, 0, 0, -1, -1, -1, 1'b0);

        vecs[0]  = mkv(mkk(0, 0, 0, 0, 0, -1, -1, -1, 1'b0), 1'b1, 0, 0);
        vecs[1]  = mkv(mkk(3, 0, 0, 0, 0, -1, -1, -1, 1'b0), 1'b1, 0, 0);
        vecs[2]  = mkv(mkk(0, 0, 0, 0, 0,  2, -1, -1, 1'b0), 1'b0, 1, 2);
        vecs[3]  = mkv(mkk(0, 0, 0, 0, 0, -1, -1,  1, 1'b0), 1'b0, 3, 1);
        vecs[4]  = mkv(mkk(0, 0, 0, 0, 0, -1, -1, -1, 1'b1), 1'b0, 4, 0);
        vecs[5]  = mkv(mkk(0, 0, 0, 0, 0, -1,  3, -1, 1'b0), 1'b0, 2, 3);
        vecs[6]  = mkv(mkk(1, 2, 0, 1, 0, -1, -1,  3, 1'b0), 1'b0, 3, 3);
        vecs[7]  = mkv(mkk(0, 0, 0, 0, 0,  0, -1, -1, 1'b0), 1'b0, 1, 0);
        vecs[8]  = mkv(mkk(4, 4, 4, 4, 4, -1, -1, -1, 1'b0), 1'b1, 0, 0);
        vecs[9]  = mkv(mkk(0, 4, 1, 2, 3, -1, -1, -1, 1'b0), 1'b1, 0, 0);
        vecs[10] = mkv(mkk(2, 1, 3, 0, 1,  1, -1, -1, 1'b0), 1'b0, 1, 1);

        // Reset state
        repeat (3) @(negedge tb_ACLK);
        check("reset.status", {busy, done, pass}, 0);
        check("reset.err", {err_idx, err_code}, 0);
        check("reset.valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check("reset.awaddr", awaddr, 0);
        check("reset.wdata", wdata, 0);
        check("prot", {awprot, arprot}, 0);
        check("wstrb", wstrb, 4'hF);
        tb_ARESET = 1'b0;

        for (int v = 0; v < 11; v++)
            run($sformatf("vec%0d", v), vecs[v].k, vecs[v].exp_pass,
                vecs[v].exp_code, vecs[v].exp_idx);

        // Fast slave: exactly 16 busy cycles; start in FIN is ignored.
        @(negedge tb_ACLK); kn = mkk(0, 0, 0, 0, 0, -1, -1, -1, 1'b0);
        busy0 = n_busy;
        start = 1'b1;
        @(negedge tb_ACLK); start = 1'b0;
        wt = 0;
        while (!done && wt < 200) begin @(negedge tb_ACLK); wt++; end
        check("fast.busy16", n_busy - busy0, 16);
        start = 1'b1;                      // FIN cycle
        @(negedge tb_ACLK); start = 1'b0;
        check("fin_start.busy", busy, 0);
        check("fin_start.done", done, 1);
        check("fin_start.pass", pass, 1);

        // Start in IDLE with done set clears the result; start while busy ignored.
        aw0 = n_aw_hs; busy0 = n_busy;
        start = 1'b1;
        @(negedge tb_ACLK); start = 1'b0;
        check("restart.done_clr", {done, pass, busy}, 3'b001);
        repeat (3) @(negedge tb_ACLK);
        start = 1'b1;
        @(negedge tb_ACLK); start = 1'b0;
        wt = 0;
        while (!done && wt < 200) begin @(negedge tb_ACLK); wt++; end
        check("busy_start.pass", {done, pass}, 2'b11);
        check("busy_start.aw_count", n_aw_hs - aw0, NUM_REGS);
        check("busy_start.busy16", n_busy - busy0, 16);

        // Reset while WVALID is high drops every VALID immediately.
        @(negedge tb_ACLK); kn = mkk(6, 6, 0, 0, 0, -1, -1, -1, 1'b0);
        start = 1'b1;
        @(negedge tb_ACLK); start = 1'b0;
        wt = 0;
        while (!wvalid && wt < 20) begin @(negedge tb_ACLK); wt++; end
        check("midrst.wvalid_seen", wvalid, 1);
        #2 tb_ARESET = 1'b1;
        #1;
        check("midrst.valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check("midrst.status", {busy, done, pass, err_code}, 0);
        @(negedge tb_ACLK); tb_ARESET = 1'b0;
        run("after_rst", mkk(0, 0, 0, 0, 0, -1, -1, -1, 1'b0), 1'b1, 0, 0);

        // Randomised scenarios against the reference model.
        for (int r = 0; r < 24; r++) begin
            int sel, reg_i;
            rk = mkk($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4), -1, -1, -1, 1'b0);
            sel   = $urandom_range(0, 4);
            reg_i = $urandom_range(0, NUM_REGS - 1);
            if (sel == 2) rk.bresp_bad = reg_i;
            if (sel == 3) rk.rresp_bad = reg_i;
            if (sel == 4) rk.data_bad  = reg_i;
            model(rk, mp, mcode, midx, naw, nar, cyc);
            run($sformatf("rnd%0d", r), rk, mp, mcode, midx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
